// File: rtl/hdc_epoch_fsm_pkg.sv
// Shared types and helpers for the HDC phase controller.
// Holds the phase enum and the minimum-one index width helper.
package hdc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_TRAIN   = 3'd1,
        S_RETRAIN = 3'd2,
        S_TEST    = 3'd3,
        S_DONE    = 3'd4
    } hdc_phase_e;

    // Bits needed to hold the values 0..n-1, never less than one bit.
    function automatic int idxWidth(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/hdc_epoch_fsm_if.sv
// Control and sample handshake bundle between the HDC phase controller and its host/datapath.
interface hdc_epoch_fsm_if #(
    parameter int IDX_W = 1,
    parameter int EP_W  = 1
);
    logic             en;
    logic             start;
    logic             abort;
    logic             sample_ack;
    logic             sample_req;
    logic [IDX_W-1:0] sample_idx;
    logic [EP_W-1:0]  epoch_idx;
    logic             training;
    logic             retraining;
    logic             testing;
    logic             phase_last;
    logic             done;

    modport master (
        input  en, start, abort, sample_ack,
        output sample_req, sample_idx, epoch_idx,
               training, retraining, testing, phase_last, done
    );

    modport slave (
        output en, start, abort, sample_ack,
        input  sample_req, sample_idx, epoch_idx,
               training, retraining, testing, phase_last, done
    );
endinterface

// File: rtl/hdc_epoch_fsm_sample_counter.sv
// Sample index up-counter: clear has priority, and it saturates at the supplied limit.
module hdc_sample_counter #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    input  logic [W-1:0] limit_i,
    output logic [W-1:0] count_o,
    output logic         tc_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign tc_o    = (count_q == limit_i);
    assign count_o = count_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !tc_o) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/hdc_epoch_fsm.sv
// Phase controller for the sparse HDC engine: one training pass, optional retraining passes,
// then one testing pass, issuing a single sample request at a time.
module hdc_epoch_fsm
    import hdc_ctrl_pkg::*;
#(
    parameter int NUM_TRAIN      = 64,
    parameter int NUM_TEST       = 32,
    parameter int RETRAIN_EPOCHS = 0,
    parameter int IDX_W          = idxWidth((NUM_TRAIN > NUM_TEST) ? NUM_TRAIN : NUM_TEST),
    parameter int EP_W           = idxWidth(RETRAIN_EPOCHS + 1)
) (
    input logic              clk,
    input logic              rst,
    hdc_epoch_fsm_if.master  bus
);

    localparam logic [IDX_W-1:0] TrainLast = IDX_W'(NUM_TRAIN - 1);
    localparam logic [IDX_W-1:0] TestLast  = IDX_W'(NUM_TEST - 1);
    localparam logic [EP_W-1:0]  EpLast    = EP_W'((RETRAIN_EPOCHS > 0) ? RETRAIN_EPOCHS - 1 : 0);

    hdc_phase_e       state_q;
    logic [EP_W-1:0]  epoch_q;
    logic [IDX_W-1:0] sampleIdx;
    logic [IDX_W-1:0] idxLimit;
    logic             idxLast;
    logic             active;
    logic             legal;
    logic             sampleReq;
    logic             sampleDone;
    logic             phaseEnd;
    logic             startRun;
    logic             idxClr;

    assign active     = (state_q == S_TRAIN) || (state_q == S_RETRAIN) || (state_q == S_TEST);
    assign legal      = active || (state_q == S_IDLE) || (state_q == S_DONE);
    assign sampleReq  = bus.en && active;
    // Abort discards any ack that lands in the same cycle.
    assign sampleDone = sampleReq && bus.sample_ack && !bus.abort;
    assign phaseEnd   = sampleDone && idxLast;
    assign startRun   = bus.en && bus.start && !bus.abort
                        && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign idxLimit   = (state_q == S_TEST) ? TestLast : TrainLast;
    assign idxClr     = bus.abort || startRun || phaseEnd || !legal;

    hdc_sample_counter #(
        .W (IDX_W)
    ) u_sample_counter (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (idxClr),
        .inc_i   (sampleDone),
        .limit_i (idxLimit),
        .count_o (sampleIdx),
        .tc_o    (idxLast)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            epoch_q <= '0;
        end else if (bus.abort) begin
            state_q <= S_IDLE;
            epoch_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (startRun) state_q <= S_TRAIN;
                end
                S_TRAIN: begin
                    if (phaseEnd) begin
                        if (RETRAIN_EPOCHS > 0) state_q <= S_RETRAIN;
                        else                    state_q <= S_TEST;
                        epoch_q <= '0;
                    end
                end
                S_RETRAIN: begin
                    if (phaseEnd) begin
                        if (epoch_q < EpLast) begin
                            epoch_q <= epoch_q + EP_W'(1);
                        end else begin
                            state_q <= S_TEST;
                            epoch_q <= '0;
                        end
                    end
                end
                S_TEST: begin
                    if (phaseEnd) state_q <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                    epoch_q <= '0;
                end
            endcase
        end
    end

    assign bus.sample_req = sampleReq;
    assign bus.sample_idx = sampleIdx;
    assign bus.epoch_idx  = epoch_q;
    assign bus.training   = (state_q == S_TRAIN);
    assign bus.retraining = (state_q == S_RETRAIN);
    assign bus.testing    = (state_q == S_TEST);
    assign bus.phase_last = sampleReq && idxLast;
    assign bus.done       = (state_q == S_DONE);

endmodule

// File: tb/tb_hdc_epoch_fsm.sv
// Self-checking bench for hdc_epoch_fsm: one instance without retraining and one with two
// retrain epochs, each with a scoreboard fed by the stimulus and drained on every accepted sample.
module tb_hdc_epoch_fsm;

    localparam logic [2:0] PhTrain   = 3'b100;
    localparam logic [2:0] PhRetrain = 3'b010;
    localparam logic [2:0] PhTest    = 3'b001;

    typedef struct packed {
        logic [2:0] flags;
        logic [7:0] idx;
        logic [7:0] epoch;
        logic       last;
    } txn_t;

    logic clk;
    logic rst;

    int   checkCount = 0;
    int   passCount  = 0;
    int   acks0      = 0;
    int   acks2      = 0;
    txn_t q0[$];
    txn_t q2[$];

    hdc_epoch_fsm_if #(.IDX_W(2), .EP_W(1)) if0 ();
    hdc_epoch_fsm_if #(.IDX_W(2), .EP_W(2)) if2 ();

    hdc_epoch_fsm #(
        .NUM_TRAIN (4), .NUM_TEST (3), .RETRAIN_EPOCHS (0), .IDX_W (2), .EP_W (1)
    ) dut0 (
        .clk (clk), .rst (rst), .bus (if0.master)
    );

    hdc_epoch_fsm #(
        .NUM_TRAIN (4), .NUM_TEST (3), .RETRAIN_EPOCHS (2), .IDX_W (2), .EP_W (2)
    ) dut2 (
        .clk (clk), .rst (rst), .bus (if2.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard for the no-retrain instance: every accepted sample must match the next expectation.
    always @(negedge clk) begin
        txn_t got;
        txn_t exp;
        if (!rst && if0.sample_req && if0.sample_ack) begin
            got = '{flags: {if0.training, if0.retraining, if0.testing}, idx: 8'(if0.sample_idx),
                    epoch: 8'(if0.epoch_idx), last: if0.phase_last};
            acks0++;
            checkCount++;
            if (q0.size() == 0) begin
                $display("[TB] FAIL sb0 unexpected sample: got flags=%b idx=%0d ep=%0d last=%b, required none",
                         got.flags, got.idx, got.epoch, got.last);
            end else begin
                exp = q0.pop_front();
                if (got === exp) passCount++;
                else $display("[TB] FAIL sb0 sample: got flags=%b idx=%0d ep=%0d last=%b, required flags=%b idx=%0d ep=%0d last=%b",
                              got.flags, got.idx, got.epoch, got.last, exp.flags, exp.idx, exp.epoch, exp.last);
            end
        end
    end

    // Scoreboard for the two-epoch retrain instance.
    always @(negedge clk) begin
        txn_t got;
        txn_t exp;
        if (!rst && if2.sample_req && if2.sample_ack) begin
            got = '{flags: {if2.training, if2.retraining, if2.testing}, idx: 8'(if2.sample_idx),
                    epoch: 8'(if2.epoch_idx), last: if2.phase_last};
            acks2++;
            checkCount++;
            if (q2.size() == 0) begin
                $display("[TB] FAIL sb2 unexpected sample: got flags=%b idx=%0d ep=%0d last=%b, required none",
                         got.flags, got.idx, got.epoch, got.last);
            end else begin
                exp = q2.pop_front();
                if (got === exp) passCount++;
                else $display("[TB] FAIL sb2 sample: got flags=%b idx=%0d ep=%0d last=%b, required flags=%b idx=%0d ep=%0d last=%b",
                              got.flags, got.idx, got.epoch, got.last, exp.flags, exp.idx, exp.epoch, exp.last);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input int sel, input logic start, input logic en,
                                 input logic abort, input logic ack);
        if (sel == 0) begin
            if0.start = start; if0.en = en; if0.abort = abort; if0.sample_ack = ack;
        end else begin
            if2.start = start; if2.en = en; if2.abort = abort; if2.sample_ack = ack;
        end
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    endtask

    // Queue the expected samples of one phase; cnt < n models a phase cut short.
    task automatic pushPhase(input int sel, input logic [2:0] flags, input int n,
                             input int cnt, input int epoch);
        txn_t t;
        for (int i = 0; i < cnt; i++) begin
            t = '{flags: flags, idx: 8'(i), epoch: 8'(epoch), last: (i == n - 1)};
            if (sel == 0) q0.push_back(t);
            else          q2.push_back(t);
        end
    endtask

    // Directed scenarios run back to back; both instances share clock and reset.
    initial begin
        int  acksStart;
        bit  dropped;
        bit  finished;

        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(2, 0, 0, 0, 0);
        #12;
        checkOutput("reset req", int'(if0.sample_req), 0);
        checkOutput("reset idx", int'(if0.sample_idx), 0);
        checkOutput("reset done", int'(if0.done), 0);
        checkOutput("reset epoch", int'(if2.epoch_idx), 0);
        rst = 1'b0;
        tick();

        // Basic run without retraining, ack every cycle.
        pushPhase(0, PhTrain, 4, 4, 0);
        pushPhase(0, PhTest, 3, 3, 0);
        applyStimulus(0, 1, 1, 0, 0);
        tick();
        checkOutput("first req", int'(if0.sample_req), 1);
        checkOutput("first training", int'(if0.training), 1);
        applyStimulus(0, 0, 1, 0, 1);
        repeat (7) tick();
        checkOutput("basic done", int'(if0.done), 1);
        checkOutput("basic req after done", int'(if0.sample_req), 0);
        checkOutput("basic sb drained", q0.size(), 0);
        repeat (2) tick();
        checkOutput("done held", int'(if0.done), 1);
        checkOutput("ack in done idx", int'(if0.sample_idx), 0);

        applyStimulus(0, 1, 1, 0, 0);
        tick();
        checkOutput("restart training", int'(if0.training), 1);
        checkOutput("restart done", int'(if0.done), 0);
        checkOutput("restart idx", int'(if0.sample_idx), 0);
        applyStimulus(0, 0, 1, 1, 0);
        tick();
        checkOutput("abort from train", int'(if0.training), 0);
        applyStimulus(0, 0, 1, 0, 1);
        repeat (2) tick();
        checkOutput("ack in idle idx", int'(if0.sample_idx), 0);
        checkOutput("ack in idle req", int'(if0.sample_req), 0);

        // Two retrain epochs, ack every cycle.
        pushPhase(2, PhTrain, 4, 4, 0);
        pushPhase(2, PhRetrain, 4, 4, 0);
        pushPhase(2, PhRetrain, 4, 4, 1);
        pushPhase(2, PhTest, 3, 3, 0);
        applyStimulus(2, 1, 1, 0, 0);
        tick();
        applyStimulus(2, 0, 1, 0, 1);
        repeat (15) tick();
        checkOutput("retrain done", int'(if2.done), 1);
        checkOutput("retrain epoch after", int'(if2.epoch_idx), 0);
        checkOutput("retrain sb drained", q2.size(), 0);
        applyStimulus(2, 0, 1, 1, 0);
        tick();

        // Ack every third cycle, en low for five cycles at training index 2.
        pushPhase(0, PhTrain, 4, 4, 0);
        pushPhase(0, PhTest, 3, 3, 0);
        applyStimulus(0, 1, 1, 0, 0);
        tick();
        acksStart = acks0;
        dropped   = 0;
        finished  = 0;
        for (int cyc = 0; cyc < 200 && !finished; cyc++) begin
            if (!dropped && if0.training && if0.sample_idx == 2) begin
                dropped = 1;
                applyStimulus(0, 0, 0, 0, 1);
                repeat (5) begin
                    tick();
                    checkOutput("en low req", int'(if0.sample_req), 0);
                    checkOutput("en low idx", int'(if0.sample_idx), 2);
                end
            end
            applyStimulus(0, 0, 1, 0, (cyc % 3 == 2));
            tick();
            if (if0.done) finished = 1;
        end
        checkOutput("stall run finished", int'(finished), 1);
        checkOutput("stall en dropped", int'(dropped), 1);
        checkOutput("stall ack count", acks0 - acksStart, 7);
        checkOutput("stall sb drained", q0.size(), 0);

        // Abort together with an ack in retrain epoch 1, index 2.
        pushPhase(2, PhTrain, 4, 4, 0);
        pushPhase(2, PhRetrain, 4, 4, 0);
        pushPhase(2, PhRetrain, 4, 3, 1);
        applyStimulus(2, 1, 1, 0, 0);
        tick();
        applyStimulus(2, 0, 1, 0, 1);
        repeat (10) tick();
        checkOutput("pre-abort retraining", int'(if2.retraining), 1);
        checkOutput("pre-abort epoch", int'(if2.epoch_idx), 1);
        checkOutput("pre-abort idx", int'(if2.sample_idx), 2);
        applyStimulus(2, 0, 1, 1, 1);
        tick();
        checkOutput("abort retraining", int'(if2.retraining), 0);
        checkOutput("abort req", int'(if2.sample_req), 0);
        checkOutput("abort idx", int'(if2.sample_idx), 0);
        checkOutput("abort epoch", int'(if2.epoch_idx), 0);
        checkOutput("abort flags", int'({if2.training, if2.testing, if2.done, if2.phase_last}), 0);
        applyStimulus(2, 0, 1, 0, 0);
        tick();
        checkOutput("post-abort idx", int'(if2.sample_idx), 0);
        checkOutput("abort sb drained", q2.size(), 0);

        // Asynchronous reset between clock edges in the middle of testing.
        pushPhase(0, PhTrain, 4, 4, 0);
        pushPhase(0, PhTest, 3, 3, 0);
        applyStimulus(0, 1, 1, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 0, 1);
        repeat (5) tick();
        checkOutput("pre-reset testing", int'(if0.testing), 1);
        checkOutput("pre-reset idx", int'(if0.sample_idx), 1);
        #3;
        rst = 1'b1;
        #1;
        checkOutput("async reset testing", int'(if0.testing), 0);
        checkOutput("async reset req", int'(if0.sample_req), 0);
        checkOutput("async reset idx", int'(if0.sample_idx), 0);
        checkOutput("async reset done", int'(if0.done), 0);
        applyStimulus(0, 0, 1, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        checkOutput("reset leftover", q0.size(), 2);
        q0.delete();
        tick();
        pushPhase(0, PhTrain, 4, 4, 0);
        pushPhase(0, PhTest, 3, 3, 0);
        applyStimulus(0, 1, 1, 0, 0);
        tick();
        applyStimulus(0, 0, 1, 0, 1);
        repeat (7) tick();
        checkOutput("post-reset done", int'(if0.done), 1);
        checkOutput("post-reset sb drained", q0.size(), 0);
        applyStimulus(0, 0, 0, 0, 0);
        tick();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
